// File: rtl/brick_hit_if.sv
// Hit request, brick RAM and redraw signals of the brick_hit block.
// Latency: none, wiring only.
// Backpressure: hit_ready gates hit_valid; draw_done releases draw_req.
//
// Ports (signals):
//   hit_valid/hit_addr/hit_ready       collision request handshake from ball logic
//   ram_addr/ram_rdata/ram_wdata/ram_we brick-health RAM, 1-cycle synchronous read
//   draw_req/draw_addr/draw_health/draw_done  redraw request to the drawer
// Modports: slave = brick_hit itself, master = the surrounding logic.
interface brick_hit_if #(
  parameter int ADDR_W = 10
);
  logic              hit_valid;
  logic [ADDR_W-1:0] hit_addr;
  logic              hit_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic [1:0]        ram_rdata;
  logic [1:0]        ram_wdata;
  logic              ram_we;
  logic              draw_req;
  logic [ADDR_W-1:0] draw_addr;
  logic [1:0]        draw_health;
  logic              draw_done;

  modport slave (
    input  hit_valid, hit_addr, ram_rdata, draw_done,
    output hit_ready, ram_addr, ram_wdata, ram_we, draw_req, draw_addr, draw_health
  );

  modport master (
    output hit_valid, hit_addr, ram_rdata, draw_done,
    input  hit_ready, ram_addr, ram_wdata, ram_we, draw_req, draw_addr, draw_health
  );
endinterface

// File: rtl/brick_hit.sv
// Brick collision read-modify-write: damages a live brick, requests redraw, tracks level health.
// Latency: miss 2 cycles, out-of-range 1 cycle, live hit writes at cycle 3 and redraws from cycle 4.
// Backpressure: hit_ready only in IDLE (no queueing); DRAW holds until draw_done.
//
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   bus (slave)      hit handshake, brick RAM port, redraw request
//   load_total       pulse: remaining <= total_health_in, marks the level loaded
//   hit_ack/hit_miss one-cycle result pulses
//   remaining        remaining total health; level_clear when loaded and zero
module brick_hit #(
  parameter int ADDR_W     = 10,
  parameter int HP_W       = 10,
  parameter int NUM_BRICKS = 128
) (
  input  logic            clk,
  input  logic            resetn,
  brick_hit_if.slave      bus,
  input  logic            load_total,
  input  logic [HP_W-1:0] total_health_in,
  output logic            hit_ack,
  output logic            hit_miss,
  output logic [HP_W-1:0] remaining,
  output logic            level_clear
);

  typedef enum logic [2:0] {IDLE, READ, EVAL, WRITE, DRAW} state_t;

  // One extra bit so the bound itself is representable even when it equals 2**ADDR_W.
  localparam logic [ADDR_W:0] NB = NUM_BRICKS[ADDR_W:0];

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              oor_q;
  logic [1:0]        health_q;
  logic              hit_ready_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [1:0]        ram_wdata_q;
  logic              ram_we_q;
  logic              hit_ack_q;
  logic              draw_req_q;
  logic [ADDR_W-1:0] draw_addr_q;
  logic [1:0]        draw_health_q;
  logic [HP_W-1:0]   remaining_q, remaining_d;
  logic              loaded_q, loaded_d;

  // A fresh load overrides a decrement landing in the same cycle.
  always_comb begin
    remaining_d = remaining_q;
    loaded_d    = loaded_q;
    if (state_q == WRITE && remaining_q != '0) remaining_d = remaining_q - HP_W'(1);
    if (load_total) begin
      remaining_d = total_health_in;
      loaded_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      oor_q         <= 1'b0;
      health_q      <= '0;
      hit_ready_q   <= 1'b1;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      ram_we_q      <= 1'b0;
      hit_ack_q     <= 1'b0;
      draw_req_q    <= 1'b0;
      draw_addr_q   <= '0;
      draw_health_q <= '0;
      remaining_q   <= '0;
      loaded_q      <= 1'b0;
    end else begin
      remaining_q <= remaining_d;
      loaded_q    <= loaded_d;
      case (state_q)
        IDLE: begin
          if (bus.hit_valid) begin
            addr_q      <= bus.hit_addr;
            hit_ready_q <= 1'b0;
            if ({1'b0, bus.hit_addr} < NB) begin
              oor_q      <= 1'b0;
              ram_addr_q <= bus.hit_addr;
              state_q    <= READ;
            end else begin
              // Out-of-range skips the RAM entirely and reports the miss next cycle.
              oor_q   <= 1'b1;
              state_q <= EVAL;
            end
          end
        end
        READ: state_q <= EVAL;
        EVAL: begin
          health_q <= bus.ram_rdata;
          if (oor_q || bus.ram_rdata == 2'd0) begin
            ram_addr_q  <= '0;
            hit_ready_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            ram_we_q    <= 1'b1;
            hit_ack_q   <= 1'b1;
            ram_wdata_q <= bus.ram_rdata - 2'd1;
            state_q     <= WRITE;
          end
        end
        WRITE: begin
          ram_we_q      <= 1'b0;
          hit_ack_q     <= 1'b0;
          ram_wdata_q   <= '0;
          ram_addr_q    <= '0;
          draw_req_q    <= 1'b1;
          draw_addr_q   <= addr_q;
          draw_health_q <= health_q - 2'd1;
          state_q       <= DRAW;
        end
        DRAW: begin
          if (bus.draw_done) begin
            draw_req_q  <= 1'b0;
            hit_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          hit_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // The miss depends on read data arriving in EVAL itself, so it is decoded, not registered.
  assign hit_miss        = (state_q == EVAL) && (oor_q || bus.ram_rdata == 2'd0);
  assign hit_ack         = hit_ack_q;
  assign bus.hit_ready   = hit_ready_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_wdata   = ram_wdata_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.draw_req    = draw_req_q;
  assign bus.draw_addr   = draw_addr_q;
  assign bus.draw_health = draw_health_q;
  assign remaining       = remaining_q;
  assign level_clear     = loaded_q && (remaining_q == '0);

endmodule

// File: tb/tb_brick_hit.sv
module tb_brick_hit;
  localparam int ADDR_W = 10;
  localparam int HP_W   = 10;

  logic            clk = 1'b0;
  logic            resetn;
  logic            load_total;
  logic [HP_W-1:0] total_health_in;
  logic            hit_ack, hit_miss, level_clear;
  logic [HP_W-1:0] remaining;

  logic              pre_we;
  logic [ADDR_W-1:0] pre_addr;
  logic [1:0]        pre_dat;
  logic [1:0]        mem [0:(1<<ADDR_W)-1];

  int checks = 0;
  int fails  = 0;

  brick_hit_if #(.ADDR_W(ADDR_W)) bus ();

  brick_hit #(.ADDR_W(ADDR_W), .HP_W(HP_W), .NUM_BRICKS(128)) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .load_total(load_total),
    .total_health_in(total_health_in), .hit_ack(hit_ack), .hit_miss(hit_miss),
    .remaining(remaining), .level_clear(level_clear)
  );

  always #5 clk = ~clk;

  // Brick RAM model: synchronous read, one-cycle latency, plus a bench preload port.
  always @(posedge clk) begin
    bus.ram_rdata <= mem[bus.ram_addr];
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    if (pre_we) mem[pre_addr] <= pre_dat;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ram_set(input logic [ADDR_W-1:0] a, input logic [1:0] v);
    pre_we = 1'b1; pre_addr = a; pre_dat = v;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic do_load(input logic [HP_W-1:0] v);
    load_total = 1'b1; total_health_in = v;
    tick();
    load_total = 1'b0;
  endtask

  // Leaves the bench at the negedge of cycle 1 (acceptance was cycle 0).
  task automatic start_hit(input logic [ADDR_W-1:0] a);
    bus.hit_valid = 1'b1; bus.hit_addr = a;
    tick();
    bus.hit_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    tick();
    checks++; if (bus.hit_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", bus.hit_ready); end
    checks++; if (remaining !== 10'd0) begin fails++; $display("FAIL reset_remaining: got %0d want 0", remaining); end
    checks++; if (level_clear !== 1'b0) begin fails++; $display("FAIL reset_level_clear: got %b want 0", level_clear); end
    checks++; if ({bus.ram_we, bus.draw_req, hit_ack, hit_miss, bus.ram_addr, bus.ram_wdata, bus.draw_addr, bus.draw_health} !== '0) begin
      fails++; $display("FAIL reset_outputs: we=%b req=%b ack=%b miss=%b raddr=%0d wdat=%0d daddr=%0d dh=%0d want all 0",
                        bus.ram_we, bus.draw_req, hit_ack, hit_miss, bus.ram_addr, bus.ram_wdata, bus.draw_addr, bus.draw_health);
    end
    do_load(10'd5);
    checks++; if (remaining !== 10'd5) begin fails++; $display("FAIL load5_remaining: got %0d want 5", remaining); end
    checks++; if (level_clear !== 1'b0) begin fails++; $display("FAIL load5_level_clear: got %b want 0", level_clear); end
    checks++; if (bus.hit_ready !== 1'b1) begin fails++; $display("FAIL load5_ready: got %b want 1", bus.hit_ready); end
  endtask

  task automatic test_live_hit();
    ram_set(10'd17, 2'd3);
    bus.draw_done = 1'b1;
    start_hit(10'd17);
    checks++; if (bus.ram_addr !== 10'd17 || bus.ram_we !== 1'b0) begin fails++; $display("FAIL live_c1_read: addr=%0d we=%b want 17/0", bus.ram_addr, bus.ram_we); end
    tick();
    checks++; if (hit_miss !== 1'b0 || bus.ram_we !== 1'b0) begin fails++; $display("FAIL live_c2: miss=%b we=%b want 0/0", hit_miss, bus.ram_we); end
    tick();
    checks++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 10'd17 || bus.ram_wdata !== 2'd2) begin
      fails++; $display("FAIL live_c3_write: we=%b addr=%0d wdata=%0d want 1/17/2", bus.ram_we, bus.ram_addr, bus.ram_wdata);
    end
    checks++; if (hit_ack !== 1'b1 || remaining !== 10'd5) begin fails++; $display("FAIL live_c3_ack: ack=%b rem=%0d want 1/5", hit_ack, remaining); end
    tick();
    checks++; if (remaining !== 10'd4) begin fails++; $display("FAIL live_c4_remaining: got %0d want 4", remaining); end
    checks++; if (bus.draw_req !== 1'b1 || bus.draw_health !== 2'd2 || bus.draw_addr !== 10'd17) begin
      fails++; $display("FAIL live_c4_draw: req=%b health=%0d addr=%0d want 1/2/17", bus.draw_req, bus.draw_health, bus.draw_addr);
    end
    checks++; if (bus.ram_we !== 1'b0 || hit_ack !== 1'b0 || bus.hit_ready !== 1'b0) begin
      fails++; $display("FAIL live_c4_pulses: we=%b ack=%b ready=%b want 0/0/0", bus.ram_we, hit_ack, bus.hit_ready);
    end
    tick();
    checks++; if (bus.draw_req !== 1'b0 || bus.hit_ready !== 1'b1) begin fails++; $display("FAIL live_c5: req=%b ready=%b want 0/1", bus.draw_req, bus.hit_ready); end
    checks++; if (mem[17] !== 2'd2) begin fails++; $display("FAIL live_ram17: got %0d want 2", mem[17]); end
  endtask

  task automatic test_dead_brick();
    logic seen_we = 1'b0;
    logic seen_req = 1'b0;
    ram_set(10'd20, 2'd0);
    start_hit(10'd20);
    checks++; if (hit_miss !== 1'b0) begin fails++; $display("FAIL dead_c1_miss: got %b want 0", hit_miss); end
    seen_we |= bus.ram_we; seen_req |= bus.draw_req;
    tick();
    checks++; if (hit_miss !== 1'b1) begin fails++; $display("FAIL dead_c2_miss: got %b want 1", hit_miss); end
    seen_we |= bus.ram_we; seen_req |= bus.draw_req;
    tick();
    checks++; if (bus.hit_ready !== 1'b1 || hit_miss !== 1'b0) begin fails++; $display("FAIL dead_c3: ready=%b miss=%b want 1/0", bus.hit_ready, hit_miss); end
    seen_we |= bus.ram_we; seen_req |= bus.draw_req;
    tick();
    seen_we |= bus.ram_we; seen_req |= bus.draw_req;
    checks++; if (seen_we !== 1'b0 || seen_req !== 1'b0) begin fails++; $display("FAIL dead_no_side_effects: we=%b req=%b want 0/0", seen_we, seen_req); end
    checks++; if (remaining !== 10'd4) begin fails++; $display("FAIL dead_remaining: got %0d want 4", remaining); end
  endtask

  task automatic test_out_of_range();
    logic [ADDR_W-1:0] addr_or = '0;
    start_hit(10'd200);
    addr_or |= bus.ram_addr;
    checks++; if (hit_miss !== 1'b1) begin fails++; $display("FAIL oor_c1_miss: got %b want 1", hit_miss); end
    tick();
    addr_or |= bus.ram_addr;
    checks++; if (bus.hit_ready !== 1'b1 || hit_miss !== 1'b0) begin fails++; $display("FAIL oor_c2: ready=%b miss=%b want 1/0", bus.hit_ready, hit_miss); end
    checks++; if (addr_or !== '0 || bus.ram_we !== 1'b0) begin fails++; $display("FAIL oor_ram_addr: or=%0d we=%b want 0/0", addr_or, bus.ram_we); end
  endtask

  task automatic test_erase_slow_draw();
    logic all_req = 1'b1;
    logic any_ready = 1'b0;
    ram_set(10'd5, 2'd1);
    do_load(10'd1);
    bus.draw_done = 1'b0;
    start_hit(10'd5);
    tick(); tick();
    checks++; if (bus.ram_we !== 1'b1 || bus.ram_wdata !== 2'd0) begin fails++; $display("FAIL erase_c3_write: we=%b wdata=%0d want 1/0", bus.ram_we, bus.ram_wdata); end
    tick();
    checks++; if (bus.draw_health !== 2'd0 || bus.draw_addr !== 10'd5) begin fails++; $display("FAIL erase_draw: health=%0d addr=%0d want 0/5", bus.draw_health, bus.draw_addr); end
    checks++; if (remaining !== 10'd0 || level_clear !== 1'b1) begin fails++; $display("FAIL erase_clear: rem=%0d clear=%b want 0/1", remaining, level_clear); end
    // A competing request during DRAW must be ignored.
    bus.hit_valid = 1'b1; bus.hit_addr = 10'd17;
    for (int i = 0; i < 5; i++) begin
      all_req &= bus.draw_req; any_ready |= bus.hit_ready;
      tick();
    end
    bus.hit_valid = 1'b0;
    bus.draw_done = 1'b1;
    all_req &= bus.draw_req;
    checks++; if (all_req !== 1'b1 || any_ready !== 1'b0) begin fails++; $display("FAIL erase_hold: req_held=%b ready_seen=%b want 1/0", all_req, any_ready); end
    tick();
    bus.draw_done = 1'b0;
    checks++; if (bus.draw_req !== 1'b0 || bus.hit_ready !== 1'b1) begin fails++; $display("FAIL erase_release: req=%b ready=%b want 0/1", bus.draw_req, bus.hit_ready); end
    checks++; if (mem[5] !== 2'd0 || mem[17] !== 2'd2) begin fails++; $display("FAIL erase_ram: m5=%0d m17=%0d want 0/2", mem[5], mem[17]); end
  endtask

  task automatic test_reset_in_draw();
    ram_set(10'd6, 2'd2);
    do_load(10'd3);
    start_hit(10'd6);
    tick(); tick(); tick();
    checks++; if (bus.draw_req !== 1'b1) begin fails++; $display("FAIL rstdraw_in_draw: req=%b want 1", bus.draw_req); end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    checks++; if (bus.draw_req !== 1'b0 || bus.hit_ready !== 1'b1) begin fails++; $display("FAIL rstdraw_state: req=%b ready=%b want 0/1", bus.draw_req, bus.hit_ready); end
    checks++; if (remaining !== 10'd0 || level_clear !== 1'b0) begin fails++; $display("FAIL rstdraw_health: rem=%0d clear=%b want 0/0", remaining, level_clear); end
    checks++; if (bus.draw_addr !== '0 || bus.draw_health !== 2'd0) begin fails++; $display("FAIL rstdraw_draw_regs: addr=%0d health=%0d want 0/0", bus.draw_addr, bus.draw_health); end
  endtask

  task automatic test_load_vs_write();
    ram_set(10'd7, 2'd3);
    bus.draw_done = 1'b1;
    start_hit(10'd7);
    tick(); tick();
    checks++; if (bus.ram_we !== 1'b1) begin fails++; $display("FAIL lvw_c3_we: got %b want 1", bus.ram_we); end
    load_total = 1'b1; total_health_in = 10'd9;
    tick();
    load_total = 1'b0;
    checks++; if (remaining !== 10'd9 || level_clear !== 1'b0) begin fails++; $display("FAIL lvw_remaining: rem=%0d clear=%b want 9/0", remaining, level_clear); end
    tick();
    checks++; if (bus.hit_ready !== 1'b1 || mem[7] !== 2'd2) begin fails++; $display("FAIL lvw_done: ready=%b m7=%0d want 1/2", bus.hit_ready, mem[7]); end
  endtask

  initial begin
    resetn = 1'b0; load_total = 1'b0; total_health_in = '0;
    pre_we = 1'b0; pre_addr = '0; pre_dat = '0;
    bus.hit_valid = 1'b0; bus.hit_addr = '0; bus.draw_done = 1'b0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 2'd0;
    @(negedge clk);
    test_reset();
    test_live_hit();
    test_dead_brick();
    test_out_of_range();
    test_erase_slow_draw();
    test_reset_in_draw();
    test_load_vs_write();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
